inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Dual-issue instruction queue directly downstream of the IF1 output stage register.
- Accepts one fetch group per cycle: 1 or 2 instructions plus PC, prediction and icache exception info.
- Splits each group into per-instruction entries and presents the two oldest entries to decode.
- Reports free space upstream through `space_ok`, `nearly_full` and `full`.

Parameters:
- DEPTH, 8, number of per-instruction entries; power of two, at least 4.
- LOG_DEPTH, 3, log2(DEPTH); width of the head and tail pointers.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  upstream group valid (the upstream stage's `readygo`).
- in_ready  out  1  queue can accept a group this cycle (drives the upstream stage's `allowin`).
- in_pc  in  32  PC of the group's first instruction.
- in_pc_next  in  32  predicted next fetch PC after the group.
- in_pc_taken  in  1  group ends in a predicted-taken branch.
- in_inst0, in_inst1  in  32 each  group instructions; inst1 is NOP when in_pc[2]=1.
- in_badv  in  32  icache faulting address.
- in_exception  in  7  icache exception code.
- in_excp_flag  in  2  per-instruction exception flag; bit0 = inst0, bit1 = inst1.
- space_ok  out  1  free entries >= 4.
- nearly_full  out  1  free entries equal 2 or 3.
- full  out  1  free entries < 2.
- out_valid  out  2  bit k = read slot k holds a valid entry.
- out0_pc, out1_pc  out  32 each  entry PC.
- out0_inst, out1_inst  out  32 each  entry instruction.
- out0_pc_next, out1_pc_next  out  32 each  predicted next PC.
- out0_taken, out1_taken  out  1 each  predicted-taken flag.
- out0_excp, out1_excp  out  1 each  entry has an icache exception.
- out_badv  out  32  badv of the oldest excepting entry in the two slots.
- out_exception  out  7  exception code of that entry.
- pop_cnt  in  2  entries decode consumes this cycle: 0, 1 or 2.
- count  out  LOG_DEPTH+1  current occupancy.

Behaviour:
- Reset (rstn=0, asynchronous):
  - head = tail = count = 0; out_valid = 0.
  - space_ok = 1, nearly_full = 0, full = 0, in_ready = 1.
  - All outN data read as pc 0, inst NOP (32'h03400000), taken 0, excp 0.
- Free space: free = DEPTH - count, evaluated on registered count before the same-cycle pop. This is deliberately conservative.
- in_ready = (free >= 2) && !flush.
- Group size n = in_pc[2] ? 1 : 2.
- Push occurs when in_valid && in_ready. Slots written at tail, tail+1 (mod DEPTH).
- Entry for inst0:
  - pc = in_pc; excp = in_excp_flag[0].
  - If n=1: pc_next = in_pc_next, taken = in_pc_taken.
  - If n=2: pc_next = in_pc+4, taken = 0.
- Entry for inst1 (n=2 only): pc = in_pc+4, pc_next = in_pc_next, taken = in_pc_taken, excp = in_excp_flag[1].
- Every entry stores in_badv and in_exception.
- Pop: head advances by pop_cnt (mod DEPTH).
  - pop_cnt > popcount(out_valid) is illegal and asserted in simulation.
  - RTL clamps the pop to the valid count.
- count_next = count + (push ? n : 0) - pop_cnt_clamped. Push and pop in the same cycle are both honoured.
- Read slots are combinational from storage:
  - out_valid[0] = count >= 1; out_valid[1] = count >= 2.
  - slot0 = entry[head], slot1 = entry[head+1 mod DEPTH].
  - An invalid slot shows NOP/zero data.
- Same-cycle bypass: a pushed group is never visible on the read slots in its push cycle; it appears the next cycle (1-cycle latency).
- out_badv / out_exception:
  - From slot0 if out0_excp.
  - Else from slot1 if out1_excp && out_valid[1].
  - Else 0.
- Pointer wrap: a two-entry write or pop spanning index DEPTH-1 to 0 wraps correctly.
- Flush: has priority over push and pop in the same cycle. Next edge gives head = tail = count = 0; the same-cycle push is dropped.
- Status flags are derived combinationally from registered count. At most one of space_ok, nearly_full, full is 1.

Test Plan:
- Fill/drain: push groups pc=0x1c000000, 0x1c000008, 0x1c000010 with no pops.
  - Expect count 2, 4, 6; space_ok=1 until count 4, then nearly_full=1 at count 6.
  - Next push gives count 8, full=1, in_ready=0.
- Odd PC: push in_pc=0x1c000004, in_pc_next=0x1c000100, taken=1.
  - Expect count=1; out0_pc=0x1c000004, out0_pc_next=0x1c000100, out0_taken=1; out_valid=2'b01.
- Split prediction: push in_pc=0x1c000000, taken=1, in_pc_next=0x1c000200.
  - Expect out0_taken=0, out0_pc_next=0x1c000004.
  - Expect out1_pc=0x1c000004, out1_taken=1, out1_pc_next=0x1c000200.
- Simultaneous push/pop with wrap:
  - Preload so head=7, count=2, then push 2 and pop_cnt=2 in the same cycle.
  - Expect count=2, new entries at indices 1 and 2, slot0 = new inst0.
- Exception select: push with in_excp_flag=2'b10, badv=0xdead0000, exception=7'h08.
  - Expect out0_excp=0, out1_excp=1, out_badv=0xdead0000, out_exception=7'h08.
  - After pop_cnt=1: out0_excp=1.
- Flush vs push: count=5 with flush=1 and in_valid=1 in the same cycle.
  - Next cycle count=0, out_valid=0, space_ok=1.
  - Also assert rstn=0 mid-stream: outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue behind IF1: splits 1/2-instruction fetch groups into
// per-instruction entries and presents the two oldest to decode.
module inst_fetch_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned LOG_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_pc_next,
    input  logic                 in_pc_taken,
    input  logic [31:0]          in_inst0,
    input  logic [31:0]          in_inst1,
    input  logic [31:0]          in_badv,
    input  logic [6:0]           in_exception,
    input  logic [1:0]           in_excp_flag,
    output logic                 space_ok,
    output logic                 nearly_full,
    output logic                 full,
    output logic [1:0]           out_valid,
    output logic [31:0]          out0_pc,
    output logic [31:0]          out1_pc,
    output logic [31:0]          out0_inst,
    output logic [31:0]          out1_inst,
    output logic [31:0]          out0_pc_next,
    output logic [31:0]          out1_pc_next,
    output logic                 out0_taken,
    output logic                 out1_taken,
    output logic                 out0_excp,
    output logic                 out1_excp,
    output logic [31:0]          out_badv,
    output logic [6:0]           out_exception,
    input  logic [1:0]           pop_cnt,
    output logic [LOG_DEPTH:0]   count
);

    localparam int unsigned CntW = LOG_DEPTH + 1;
    localparam logic [31:0] Nop = 32'h0340_0000;

    logic [31:0] pc_mem      [DEPTH];
    logic [31:0] inst_mem    [DEPTH];
    logic [31:0] pc_next_mem [DEPTH];
    logic        taken_mem   [DEPTH];
    logic        excp_mem    [DEPTH];
    logic [31:0] badv_mem    [DEPTH];
    logic [6:0]  exc_mem     [DEPTH];

    logic [LOG_DEPTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [LOG_DEPTH-1:0] head_p1, tail_p1;
    logic [CntW-1:0]      count_q, count_d;
    logic [CntW-1:0]      free, push_n, vld_cnt, pop_req, pop_eff;
    logic                 push, single;
    logic                 vld0, vld1;

    assign head_p1 = head_q + LOG_DEPTH'(1);
    assign tail_p1 = tail_q + LOG_DEPTH'(1);

    // Flow control looks only at registered occupancy, ignoring any same-cycle pop.
    assign free        = CntW'(DEPTH) - count_q;
    assign in_ready    = (free >= CntW'(2)) && !flush;
    assign space_ok    = free >= CntW'(4);
    assign nearly_full = (free == CntW'(2)) || (free == CntW'(3));
    assign full        = free < CntW'(2);
    assign count       = count_q;

    assign single  = in_pc[2];
    assign push    = in_valid && in_ready;
    assign push_n  = push ? (single ? CntW'(1) : CntW'(2)) : '0;
    assign vld_cnt = (count_q >= CntW'(2)) ? CntW'(2) : count_q;
    assign pop_req = CntW'(pop_cnt);
    assign pop_eff = (pop_req > vld_cnt) ? vld_cnt : pop_req;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + pop_eff[LOG_DEPTH-1:0];
            tail_d  = tail_q + push_n[LOG_DEPTH-1:0];
            count_d = count_q + push_n - pop_eff;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: invalid slots are masked on the read side.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]      <= in_pc;
            inst_mem[tail_q]    <= in_inst0;
            pc_next_mem[tail_q] <= single ? in_pc_next : in_pc + 32'd4;
            taken_mem[tail_q]   <= single ? in_pc_taken : 1'b0;
            excp_mem[tail_q]    <= in_excp_flag[0];
            badv_mem[tail_q]    <= in_badv;
            exc_mem[tail_q]     <= in_exception;
            if (!single) begin
                pc_mem[tail_p1]      <= in_pc + 32'd4;
                inst_mem[tail_p1]    <= in_inst1;
                pc_next_mem[tail_p1] <= in_pc_next;
                taken_mem[tail_p1]   <= in_pc_taken;
                excp_mem[tail_p1]    <= in_excp_flag[1];
                badv_mem[tail_p1]    <= in_badv;
                exc_mem[tail_p1]     <= in_exception;
            end
        end
    end

    assign vld0      = count_q >= CntW'(1);
    assign vld1      = count_q >= CntW'(2);
    assign out_valid = {vld1, vld0};

    always_comb begin
        out0_pc       = '0;
        out0_inst     = Nop;
        out0_pc_next  = '0;
        out0_taken    = 1'b0;
        out0_excp     = 1'b0;
        out1_pc       = '0;
        out1_inst     = Nop;
        out1_pc_next  = '0;
        out1_taken    = 1'b0;
        out1_excp     = 1'b0;
        out_badv      = '0;
        out_exception = '0;
        if (vld0) begin
            out0_pc      = pc_mem[head_q];
            out0_inst    = inst_mem[head_q];
            out0_pc_next = pc_next_mem[head_q];
            out0_taken   = taken_mem[head_q];
            out0_excp    = excp_mem[head_q];
        end
        if (vld1) begin
            out1_pc      = pc_mem[head_p1];
            out1_inst    = inst_mem[head_p1];
            out1_pc_next = pc_next_mem[head_p1];
            out1_taken   = taken_mem[head_p1];
            out1_excp    = excp_mem[head_p1];
        end
        if (out0_excp) begin
            out_badv      = badv_mem[head_q];
            out_exception = exc_mem[head_q];
        end else if (out1_excp) begin
            out_badv      = badv_mem[head_p1];
            out_exception = exc_mem[head_p1];
        end
    end

    pop_legal_a: assert property (@(posedge clk) disable iff (!rstn)
        ({1'b0, pop_cnt} <= ({2'b0, out_valid[0]} + {2'b0, out_valid[1]})));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a queue-based reference of stored entries.
module tb_inst_fetch_queue;

    localparam logic [31:0] NOP = 32'h0340_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0, in_pc_next = '0, in_inst0 = '0, in_inst1 = '0, in_badv = '0;
    logic        in_pc_taken = 1'b0;
    logic [6:0]  in_exception = '0;
    logic [1:0]  in_excp_flag = '0;
    logic        space_ok, nearly_full, full;
    logic [1:0]  out_valid;
    logic [31:0] out0_pc, out1_pc, out0_inst, out1_inst, out0_pc_next, out1_pc_next, out_badv;
    logic        out0_taken, out1_taken, out0_excp, out1_excp;
    logic [6:0]  out_exception;
    logic [1:0]  pop_cnt = '0;
    logic [3:0]  count;

    inst_fetch_queue #(.DEPTH(8), .LOG_DEPTH(3)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pc_next(in_pc_next), .in_pc_taken(in_pc_taken),
        .in_inst0(in_inst0), .in_inst1(in_inst1), .in_badv(in_badv),
        .in_exception(in_exception), .in_excp_flag(in_excp_flag),
        .space_ok(space_ok), .nearly_full(nearly_full), .full(full), .out_valid(out_valid),
        .out0_pc(out0_pc), .out1_pc(out1_pc), .out0_inst(out0_inst), .out1_inst(out1_inst),
        .out0_pc_next(out0_pc_next), .out1_pc_next(out1_pc_next),
        .out0_taken(out0_taken), .out1_taken(out1_taken),
        .out0_excp(out0_excp), .out1_excp(out1_excp),
        .out_badv(out_badv), .out_exception(out_exception),
        .pop_cnt(pop_cnt), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc_next;
        logic        taken;
        logic        excp;
        logic [31:0] badv;
        logic [6:0]  exc;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ent_t slot_exp(input int k);
        ent_t e;
        e = '{pc: 32'h0, inst: NOP, pc_next: 32'h0, taken: 1'b0, excp: 1'b0,
              badv: 32'h0, exc: 7'h0};
        if (k < sb.size()) e = sb[k];
        return e;
    endfunction

    task automatic check_state();
        ent_t e0, e1;
        int   fr;
        logic [31:0] eb;
        logic [6:0]  ex;
        e0 = slot_exp(0);
        e1 = slot_exp(1);
        fr = 8 - sb.size();
        chk("count", 32'(count), 32'(sb.size()));
        chk("out_valid", 32'(out_valid), {30'b0, sb.size() >= 2, sb.size() >= 1});
        chk("space_ok", 32'(space_ok), 32'(fr >= 4));
        chk("nearly_full", 32'(nearly_full), 32'(fr == 2 || fr == 3));
        chk("full", 32'(full), 32'(fr < 2));
        chk("out0_pc", out0_pc, e0.pc);
        chk("out0_inst", out0_inst, e0.inst);
        chk("out0_pc_next", out0_pc_next, e0.pc_next);
        chk("out0_taken", 32'(out0_taken), 32'(e0.taken));
        chk("out0_excp", 32'(out0_excp), 32'(e0.excp));
        chk("out1_pc", out1_pc, e1.pc);
        chk("out1_inst", out1_inst, e1.inst);
        chk("out1_pc_next", out1_pc_next, e1.pc_next);
        chk("out1_taken", 32'(out1_taken), 32'(e1.taken));
        chk("out1_excp", 32'(out1_excp), 32'(e1.excp));
        eb = 32'h0;
        ex = 7'h0;
        if (e0.excp) begin
            eb = e0.badv;
            ex = e0.exc;
        end else if (e1.excp) begin
            eb = e1.badv;
            ex = e1.exc;
        end
        chk("out_badv", out_badv, eb);
        chk("out_exception", 32'(out_exception), 32'(ex));
    endtask

    // One clock: drive a group and/or pop, update the reference, check after the edge.
    task automatic cycle(input logic vld, input logic [31:0] pc, input logic [31:0] pcn,
                         input logic tk, input logic [1:0] fl, input logic [31:0] bv,
                         input logic [6:0] ec, input int pop, input logic fsh);
        logic exp_ready;
        ent_t e;
        in_valid     = vld;
        in_pc        = pc;
        in_pc_next   = pcn;
        in_pc_taken  = tk;
        in_excp_flag = fl;
        in_badv      = bv;
        in_exception = ec;
        in_inst0     = $urandom;
        in_inst1     = $urandom;
        pop_cnt      = 2'(pop);
        flush        = fsh;
        #1;
        exp_ready = ((8 - sb.size()) >= 2) && !fsh;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (fsh) begin
            sb.delete();
        end else begin
            for (int i = 0; i < pop; i++) void'(sb.pop_front());
            if (vld && exp_ready) begin
                if (pc[2]) begin
                    e = '{pc: pc, inst: in_inst0, pc_next: pcn, taken: tk, excp: fl[0],
                          badv: bv, exc: ec};
                    sb.push_back(e);
                end else begin
                    e = '{pc: pc, inst: in_inst0, pc_next: pc + 32'd4, taken: 1'b0,
                          excp: fl[0], badv: bv, exc: ec};
                    sb.push_back(e);
                    e = '{pc: pc + 32'd4, inst: in_inst1, pc_next: pcn, taken: tk,
                          excp: fl[1], badv: bv, exc: ec};
                    sb.push_back(e);
                end
            end
        end
        #1;
        in_valid = 1'b0;
        pop_cnt  = 2'd0;
        flush    = 1'b0;
        #1;
        check_state();
    endtask

    task automatic push(input logic [31:0] pc, input int pop);
        cycle(1'b1, pc, pc + 32'h8, 1'b0, 2'b00, 32'h0, 7'h0, pop, 1'b0);
    endtask

    task automatic pop_only(input int pop);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 7'h0, pop, 1'b0);
    endtask

    initial begin
        // Reset state
        #3;
        check_state();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;

        // Fill / drain
        push(32'h1c00_0000, 0);
        push(32'h1c00_0008, 0);
        push(32'h1c00_0010, 0);
        chk("fill6_nearly_full", 32'(nearly_full), 32'd1);
        push(32'h1c00_0018, 0);
        chk("fill8_full", 32'(full), 32'd1);
        chk("fill8_in_ready", 32'(in_ready), 32'd0);
        push(32'h1c00_0020, 0);
        for (int i = 0; i < 4; i++) pop_only(2);

        // Odd PC: single-instruction group keeps the group prediction
        cycle(1'b1, 32'h1c00_0004, 32'h1c00_0100, 1'b1, 2'b00, 32'h0, 7'h0, 0, 1'b0);
        chk("odd_pc", out0_pc, 32'h1c00_0004);
        chk("odd_pc_next", out0_pc_next, 32'h1c00_0100);
        chk("odd_taken", 32'(out0_taken), 32'd1);
        pop_only(1);

        // Split prediction
        cycle(1'b1, 32'h1c00_0000, 32'h1c00_0200, 1'b1, 2'b00, 32'h0, 7'h0, 0, 1'b0);
        chk("split_pc_next0", out0_pc_next, 32'h1c00_0004);
        chk("split_pc_next1", out1_pc_next, 32'h1c00_0200);
        chk("split_taken1", 32'(out1_taken), 32'd1);
        pop_only(2);

        // Move head to 7, then wrap a write and a simultaneous push/pop
        push(32'h1c00_1000, 0);
        push(32'h1c00_1008, 0);
        pop_only(2);
        pop_only(2);
        push(32'h1c00_2000, 0);
        push(32'h1c00_3000, 2);
        chk("wrap_slot0_pc", out0_pc, 32'h1c00_3000);
        pop_only(2);

        // Exception select
        cycle(1'b1, 32'h1c00_4000, 32'h1c00_4008, 1'b0, 2'b10, 32'hdead_0000, 7'h08, 0, 1'b0);
        chk("excp_badv", out_badv, 32'hdead_0000);
        chk("excp_code", 32'(out_exception), 32'h08);
        pop_only(1);
        chk("excp_slot0", 32'(out0_excp), 32'd1);
        pop_only(1);

        // Flush beats a same-cycle push
        push(32'h1c00_5000, 0);
        push(32'h1c00_5008, 0);
        cycle(1'b1, 32'h1c00_5014, 32'h1c00_5018, 1'b0, 2'b00, 32'h0, 7'h0, 0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd5);
        cycle(1'b1, 32'h1c00_6000, 32'h1c00_6008, 1'b0, 2'b00, 32'h0, 7'h0, 0, 1'b1);
        chk("flush_space_ok", 32'(space_ok), 32'd1);

        // Asynchronous reset mid-stream
        push(32'h1c00_7000, 0);
        #2;
        rstn = 1'b0;
        #1;
        sb.delete();
        check_state();
        #10;
        rstn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
